// File: rtl/four_bit_us_multiplier_pkg.sv
// Shared widths and types for the 4x4 unsigned array multiplier.
// Optional macro: FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN (used by the top).
package four_bit_us_multiplier_pkg;

   localparam int OPND_W = 4;
   localparam int PROD_W = 8;

   typedef logic [OPND_W-1:0] opnd_t;
   typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/fbm_full_adder.sv
// One-bit full adder cell of the multiplier array.
// Half-adder positions tie cin low.
module fbm_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign s     = w_axb ^ cin;
   assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/four_bit_us_multiplier.sv
// 4x4 unsigned array multiplier: 16 AND terms, 3 ripple rows of full adders.
// FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN selects a combinational Product.
module four_bit_us_multiplier
   import four_bit_us_multiplier_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  opnd_t A,
   input  opnd_t B,
   output prod_t Product
);

   logic [OPND_W-1:0] w_pp    [0:OPND_W-1];
   logic [OPND_W-1:0] w_row_b [1:OPND_W-1];
   logic [OPND_W-1:0] w_row_ci[1:OPND_W-1];
   logic [OPND_W-1:0] w_s     [1:OPND_W-1];
   logic [OPND_W-1:0] w_c     [1:OPND_W-1];
   prod_t             w_prod;

   // w_pp[i][j] carries weight 2^(i+j)
   for (genvar i = 0; i < OPND_W; i++) begin : g_pp_row
      for (genvar j = 0; j < OPND_W; j++) begin : g_pp_bit
         assign w_pp[i][j] = A[j] & B[i];
      end
   end

   for (genvar r = 1; r < OPND_W; r++) begin : g_row
      for (genvar j = 0; j < OPND_W; j++) begin : g_cell
         if (r == 1) begin : g_b_first
            if (j < OPND_W-1) begin : g_b_pp
               assign w_row_b[r][j] = w_pp[0][j+1];
            end else begin : g_b_zero
               assign w_row_b[r][j] = 1'b0;
            end
         end else begin : g_b_next
            if (j < OPND_W-1) begin : g_b_sum
               assign w_row_b[r][j] = w_s[r-1][j+1];
            end else begin : g_b_carry
               assign w_row_b[r][j] = w_c[r-1][OPND_W-1];
            end
         end

         if (j == 0) begin : g_ci_zero
            assign w_row_ci[r][j] = 1'b0;
         end else begin : g_ci_ripple
            assign w_row_ci[r][j] = w_c[r][j-1];
         end

         fbm_full_adder u_fa (
            .a   (w_pp[r][j]),
            .b   (w_row_b[r][j]),
            .cin (w_row_ci[r][j]),
            .s   (w_s[r][j]),
            .cout(w_c[r][j])
         );
      end
   end

   assign w_prod = {w_c[OPND_W-1][OPND_W-1],
                    w_s[OPND_W-1],
                    w_s[2][0],
                    w_s[1][0],
                    w_pp[0][0]};

`ifdef FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN
   logic w_unused;

   assign w_unused = clk ^ rst_n;
   assign Product  = w_prod;
`else
   prod_t r_product;

   always_ff @(posedge clk) begin
      if (!rst_n) r_product <= '0;
      else        r_product <= w_prod;
   end

   assign Product = r_product;
`endif

endmodule

// File: tb/tb_four_bit_us_multiplier.sv
// Scoreboard bench for four_bit_us_multiplier, registered or combinational build.
module tb_four_bit_us_multiplier;
   import four_bit_us_multiplier_pkg::*;

   logic  clk;
   logic  rst_n;
   opnd_t A;
   opnd_t B;
   prod_t Product;

   prod_t q_exp [$];
   string q_name[$];
   int    total;
   int    bad;
   bit    drv_done;

   four_bit_us_multiplier dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .Product(Product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected value while reset is asserted depends on the build.
   function automatic prod_t rst_exp(input prod_t comb_val);
`ifdef FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN
      return comb_val;
`else
      return 8'd0;
`endif
   endfunction

   task automatic drive(input logic r, input opnd_t a, input opnd_t b,
                        input prod_t exp, input string nm);
      rst_n = r;
      A     = a;
      B     = b;
      q_exp.push_back(exp);
      q_name.push_back(nm);
      @(negedge clk);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      drv_done = 1'b0;
      drive(1'b0, 4'd15, 4'd15, rst_exp(8'd225), "reset");
      drive(1'b1, 4'd15, 4'd15, 8'd225, "15x15");
      drive(1'b1, 4'd0,  4'd13, 8'd0,   "0x13");
      drive(1'b1, 4'd13, 4'd0,  8'd0,   "13x0");
      drive(1'b1, 4'd1,  4'd9,  8'd9,   "1x9");
      drive(1'b1, 4'd10, 4'd12, 8'd120, "10x12");
      drive(1'b1, 4'd8,  4'd8,  8'd64,  "8x8");
      drive(1'b1, 4'd3,  4'd5,  8'd15,  "stream3x5");
      drive(1'b1, 4'd7,  4'd7,  8'd49,  "stream7x7");
      drive(1'b1, 4'd15, 4'd1,  8'd15,  "stream15x1");
      drive(1'b0, 4'd6,  4'd7,  rst_exp(8'd42), "midrst");
      drive(1'b1, 4'd6,  4'd7,  8'd42,  "after_rst");
      drive(1'b1, 4'd1,  4'd15, 8'd15,  "1x15");
      drive(1'b1, 4'd15, 4'd14, 8'd210, "15x14");
      for (int k = 0; k < 12; k++) begin
         opnd_t ra;
         opnd_t rb;
         ra = opnd_t'($urandom_range(15));
         rb = opnd_t'($urandom_range(15));
         drive(1'b1, ra, rb, prod_t'(ra) * prod_t'(rb), "random");
      end
      drv_done = 1'b1;
   end

   initial begin
      int    cyc;
      prod_t e;
      string n;
      cyc = 0;
      while (!(drv_done && q_exp.size() == 0) && cyc < 1000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n = q_name.pop_front();
            total++;
            if (Product !== e) begin
               bad++;
               $display("FAIL %s: got %0d expected %0d", n, Product, e);
            end
         end
      end
      if (cyc >= 1000) begin
         total++;
         bad++;
         $display("FAIL timeout: got %0d pending expected 0", q_exp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/four_bit_us_multiplier.md
FOUR_BIT_US_MULTIPLIER -- requirements
Module: four_bit_us_multiplier

Interface
REQ-001 Parameters: none SHALL exist; widths come from package constants (operand 4, product 8).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 A  input  4  unsigned multiplicand.
REQ-005 B  input  4  unsigned multiplier.
REQ-006 Product  output  8  unsigned product A*B.

Function
REQ-007 Product SHALL equal the full unsigned 8-bit product A*B: no truncation, no sign extension, range 0..225.
REQ-008 Default build: Product SHALL be registered and SHALL update on every rising clk edge with A*B of the A/B values sampled at that edge, giving 1-cycle latency.
REQ-009 The multiplier SHALL be fully pipelined at one result per cycle, with no handshake, no enable and no busy state.
REQ-010 The datapath SHALL be a structural array multiplier: 16 AND partial products, then 3 ripple rows of adder cells.
REQ-011 Behavioural "*" SHALL NOT be used in synthesizable RTL.
REQ-012 Product SHALL be a pure function of the sampled operands, with no dependence on prior operands.
REQ-013 Operands SHALL be treated as unsigned at the boundaries: 0*x=0, 15*15=225, 1*x=x.
REQ-014 X/Z on A or B SHALL NOT corrupt the register beyond that one sample; the next valid sample fully determines Product.

Reset
REQ-015 While rst_n=0 at a rising clk edge, Product SHALL become 8'h00 regardless of A and B.
REQ-016 Reset SHALL take precedence over the new product when asserted mid-stream.
REQ-017 On the first edge with rst_n=1, Product SHALL load A*B normally, with no extra bubble.
REQ-018 No asynchronous reset path SHALL exist.

Configuration
REQ-019 Macro FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN, when defined: Product SHALL be driven combinationally from A and B (latency 0, valid within the same cycle).
REQ-020 With FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN defined, clk and rst_n SHALL remain ports but SHALL have no effect on Product.
REQ-021 Macro FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN, when undefined: the registered behaviour of REQ-008 and REQ-015 SHALL apply.

Structure
REQ-022 Package four_bit_us_multiplier_pkg SHALL hold OPND_W=4, PROD_W=8, and typedefs opnd_t (logic[3:0]) and prod_t (logic[7:0]).
REQ-023 One sub-module, fbm_full_adder (inputs a, b, cin; outputs s, cout), SHALL be instantiated for every adder cell of the array.
REQ-024 Half-adder positions SHALL use fbm_full_adder with cin tied to 0.

Verification
REQ-025 Reset: rst_n=0, A=15, B=15, one edge -> Product=0.
REQ-026 Release and extremes: rst_n=1; apply A=15, B=15 -> Product=225 one edge later; apply A=0, B=13 -> Product=0.
REQ-027 Identity and mid values: A=1, B=9 -> 9; A=10, B=12 -> 120; A=8, B=8 -> 64.
REQ-028 Back-to-back streaming: A/B changed every cycle over (3,5), (7,7), (15,1) -> Product 15, 49, 15 on consecutive cycles.
REQ-029 Reset mid-stream: A=6, B=7 with rst_n dropped for one edge -> Product=0 on that edge, then 42 on the next edge.
REQ-030 Random: at least 10 random vector pairs, each checked as Product==A*B one cycle after application (same cycle with FOUR_BIT_US_MULTIPLIER_COMB_OUT_EN), including a run with the macro defined.
